// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 serial command receiver for the BLE command link.
// Turns frames on RX into a byte (rx_data) plus a sticky ready flag (rdy).
// Optional feature macro: UART_RX_FRAME_ERR_EN. When it is defined, a stop-bit
// sample of 0 raises frame_err instead of rdy. When it is not defined,
// frame_err is tied to 0 and every completed frame raises rdy.
//
// Output handshake: rdy is a sticky "valid" for rx_data. The consumer
// acknowledges with a one-cycle clr_rdy, and rdy drops on the next clock.
// A new start bit also drops rdy. If a new byte sets rdy in the same cycle
// that clr_rdy is high, the set wins so no byte is silently lost. rx_data is
// stable from the cycle rdy rises until the next frame completes.
module uart_cmd_rx #(
   parameter int BAUD_CNT = 2604  // clocks per bit; even and >= 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frame_err
);

   localparam int            CW       = $clog2(BAUD_CNT) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(BAUD_CNT);
   localparam logic [CW-1:0] HALF_CNT = CW'(BAUD_CNT / 2);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [3:0]    STOP_IDX = 4'd9;

   typedef enum logic {
      IDLE    = 1'b0,
      RECEIVE = 1'b1
   } state_t;

   // FSM state. It is a plain named register so checkers can bind to it.
   state_t          state;
   state_t          state_nxt;

   logic            rx_meta;
   logic            rx_sync;
   logic [CW-1:0]   baud_cnt;
   logic [3:0]      bit_cnt;
   logic [8:0]      shift_reg;
   logic            armed;      // line has been seen high while idle
   logic            done_pend;  // stop bit sampled last cycle

   logic            start_det;
   logic            sample_tick;
   logic            false_start;
   logic            frame_done;
   logic            set_rdy;

   // Two-flop synchronizer. It resets to the idle level, so a pin held low
   // during reset does not look like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= RX;
         rx_sync <= rx_meta;
      end
   end

   // Start detection needs a high-to-low edge. After reset, after a break,
   // or after a stop bit of 0, the line must be seen high in IDLE before a
   // low is accepted. This keeps the tail of an interrupted frame from
   // being taken as a new start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed <= 1'b0;
      end else if (start_det) begin
         armed <= 1'b0;
      end else if ((state == IDLE) && rx_sync) begin
         armed <= 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and per-cycle control strobes.
   // A sample is taken on the cycle where baud_cnt would count down to zero.
   // So the first sample comes BAUD_CNT/2 clocks after detection, and each
   // later sample comes exactly BAUD_CNT clocks after the one before it.
   always_comb begin
      state_nxt   = state;
      start_det   = 1'b0;
      sample_tick = 1'b0;
      false_start = 1'b0;
      frame_done  = 1'b0;
      case (state)
         IDLE: begin
            if (armed && !rx_sync) begin
               start_det = 1'b1;
               state_nxt = RECEIVE;
            end
         end
         RECEIVE: begin
            if (baud_cnt == ONE_CNT) begin
               sample_tick = 1'b1;
               if ((bit_cnt == 4'd0) && rx_sync) begin
                  // The start bit is high at mid-bit, so this was a glitch.
                  false_start = 1'b1;
                  state_nxt   = IDLE;
               end else if (bit_cnt == STOP_IDX) begin
                  // Go back to IDLE in the middle of the stop bit, so a start
                  // edge right after the stop bit is still caught.
                  frame_done = 1'b1;
                  state_nxt  = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Baud and bit counters. bit_cnt runs 0 (start) .. 9 (stop), and
   // baud_cnt stays between 1 and BAUD_CNT while the FSM is receiving.
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (start_det) begin
         baud_cnt <= HALF_CNT;
         bit_cnt  <= '0;
      end else if (frame_done || false_start) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (sample_tick) begin
         baud_cnt <= FULL_CNT;
         bit_cnt  <= bit_cnt + 4'd1;
      end else if (state == RECEIVE) begin
         baud_cnt <= baud_cnt - ONE_CNT;
      end
   end

   // Shift samples 1..9 in from the MSB side. After the stop sample, the
   // register holds {stop, d7 .. d0}, with the data LSB-aligned.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
      end else if (sample_tick && (bit_cnt != 4'd0)) begin
         shift_reg <= {rx_sync, shift_reg[8:1]};
      end
   end

   // Delay the frame-complete strobe by one clock so that the shift register
   // already holds the stop bit when rx_data and the flags update.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_pend <= 1'b0;
      end else begin
         done_pend <= frame_done;
      end
   end

   // rx_data keeps the last completed byte. It is not cleared by clr_rdy.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data <= 8'h00;
      end else if (done_pend) begin
         rx_data <= shift_reg[7:0];
      end
   end

`ifdef UART_RX_FRAME_ERR_EN
   logic frame_err_q;

   assign set_rdy = done_pend && shift_reg[8];

   // Stop-bit error flag. It follows the same set-wins rule as rdy.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err_q <= 1'b0;
      end else if (done_pend && !shift_reg[8]) begin
         frame_err_q <= 1'b1;
      end else if (clr_rdy || start_det) begin
         frame_err_q <= 1'b0;
      end
   end

   assign frame_err = frame_err_q;
`else
   assign set_rdy   = done_pend;
   assign frame_err = 1'b0;
`endif

   // Sticky ready flag. Setting it has priority over clr_rdy and over a new
   // start detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdy <= 1'b0;
      end else if (set_rdy) begin
         rdy <= 1'b1;
      end else if (clr_rdy || start_det) begin
         rdy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: directed and randomized frames on RX for uart_cmd_rx.
// A reference model predicts each frame's outcome ({rdy, frame_err, byte})
// and its rdy latency from the start edge. A monitor compares these
// predictions against what the receiver produces.
module tb_uart_cmd_rx;

   localparam int BAUD    = 32;
   localparam int HALF    = BAUD / 2;
   localparam int RDY_LAT = HALF + 9 * BAUD;  // nominal, plus 3..4 clocks
`ifdef UART_RX_FRAME_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       RX;
   logic       clr_rdy;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frame_err;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;

   // Scoreboard: expected {rdy, frame_err, rx_data} per frame, plus the
   // cycle of that frame's start edge.
   logic [9:0] exp_q[$];
   int         exp_t[$];
   logic [7:0] model_data = 8'h00;
   logic       mon_en = 1'b0;
   logic       rdy_p  = 1'b0;
   logic       fe_p   = 1'b0;

   uart_cmd_rx #(.BAUD_CNT(BAUD)) dut (
      .clk       (clk),
      .rst       (rst),
      .RX        (RX),
      .clr_rdy   (clr_rdy),
      .rx_data   (rx_data),
      .rdy       (rdy),
      .frame_err (frame_err)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Monitor: each rising edge of rdy or frame_err completes one frame.
   always @(negedge clk) begin
      int         lat;
      logic [9:0] e;
      if (mon_en && ((rdy && !rdy_p) || (frame_err && !fe_p))) begin
         if (exp_q.size() == 0) begin
            check("spurious_event", 32'({rdy, frame_err}), 32'd0);
         end else begin
            e   = exp_q.pop_front();
            lat = cyc - exp_t.pop_front();
            model_data = e[7:0];
            check("frame_result", 32'({rdy, frame_err, rx_data}), 32'(e));
            check("rdy_latency",
                  ((lat >= RDY_LAT - 1) && (lat <= RDY_LAT + 8)) ? RDY_LAT + 4 : lat,
                  RDY_LAT + 4);
         end
      end
      rdy_p = rdy;
      fe_p  = frame_err;
   end

   // ---------------- driver tasks ----------------
   // Advance n clock edges, then settle 1 time unit after the last edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   // Send one 8N1 frame, LSB first. If abort_bit >= 0, pulse rst in the
   // middle of that data bit, then return the line to idle.
   task automatic send_byte(input logic [7:0] d, input logic stop, input int abort_bit);
      if (abort_bit < 0) begin
         exp_q.push_back({(ERR_EN && !stop) ? 2'b01 : 2'b10, d});
         exp_t.push_back(cyc);
      end
      RX = 1'b0;
      tick(BAUD);
      check("start_clears_flags", 32'({rdy, frame_err}), 32'd0);
      for (int i = 0; i < 8; i++) begin
         RX = d[i];
         if (i == abort_bit) begin
            tick(HALF);
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            RX  = 1'b1;
            model_data = 8'h00;
            check("abort_rx_data", 32'(rx_data), 32'(model_data));
            check("abort_flags", 32'({rdy, frame_err}), 32'd0);
            return;
         end
         tick(BAUD);
      end
      RX = stop;
      tick(BAUD);
      RX = 1'b1;
   endtask

   // Short low pulse on an idle line: a false start, with no byte produced.
   task automatic glitch(input int len);
      RX = 1'b0;
      tick(len);
      RX = 1'b1;
      tick(2 * BAUD);
      check("glitch_flags", 32'({rdy, frame_err}), 32'd0);
      check("glitch_rx_data", 32'(rx_data), 32'(model_data));
   endtask

   task automatic clr_pulse();
      clr_rdy = 1'b1;
      tick(1);
      clr_rdy = 1'b0;
      check("clr_rdy", 32'(rdy), 32'd0);
      check("clr_frame_err", 32'(frame_err), 32'd0);
      check("clr_keeps_data", 32'(rx_data), 32'(model_data));
   endtask

   task automatic drained(input string tag);
      tick(4);
      check(tag, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      exp_t.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         gap;
      int         kind;
      logic       stop;
      logic [7:0] d;

      rst     = 1'b1;
      RX      = 1'b1;
      clr_rdy = 1'b0;
      tick(4);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Idle line after reset.
      tick(10000);
      check("reset_rdy", 32'(rdy), 32'd0);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_frame_err", 32'(frame_err), 32'd0);

      // Single 'g' command, then acknowledge.
      send_byte(8'h67, 1'b1, -1);
      drained("frame_67");
      check("rdy_sticky", 32'(rdy), 32'd1);
      check("rx_data_67", 32'(rx_data), 32'h67);
      clr_pulse();

      // Back-to-back frames with no idle gap and no acknowledge.
      tick(20);
      send_byte(8'h73, 1'b1, -1);
      send_byte(8'hA5, 1'b1, -1);
      drained("b2b_frames");
      check("b2b_last", 32'({rdy, rx_data}), 32'h1A5);

      // A glitch while rdy is still set clears rdy. After an acknowledge,
      // another glitch leaves rdy low. Then a real frame is received.
      tick(8);
      glitch(HALF - 4);
      clr_pulse();
      glitch(HALF - 4);
      send_byte(8'h67, 1'b1, -1);
      drained("after_glitch");

      // Frame 0x55 with a stop bit of 0.
      clr_pulse();
      send_byte(8'h55, 1'b0, -1);
      drained("bad_stop");
      check("bad_stop_state", 32'({rdy, frame_err, rx_data}),
            32'({ERR_EN ? 2'b01 : 2'b10, 8'h55}));
      clr_pulse();

      // Reset during bit 4 of 0x67, then a clean 0x73.
      tick(8);
      send_byte(8'h67, 1'b1, 4);
      tick(12 * BAUD);
      drained("aborted_frame");
      send_byte(8'h73, 1'b1, -1);
      drained("after_abort");
      check("after_abort_data", 32'({rdy, rx_data}), 32'h173);

      // Randomized frames, gaps, acknowledges and glitches.
      for (int n = 0; n < 30; n++) begin
         d    = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 7) != 0);
         send_byte(d, stop, -1);
         gap  = stop ? $urandom_range(0, 2 * BAUD) : $urandom_range(4, 2 * BAUD);
         if (gap > 0) tick(gap);
         kind = $urandom_range(0, 3);
         if (kind == 1) clr_pulse();
         if (kind == 2) glitch($urandom_range(2, HALF - 4));
      end
      drained("random_frames");

      tick(2 * BAUD);
      check("final_rx_data", 32'(rx_data), 32'(model_data));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
